// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: pushes rx_data on each rise of the
// received level, pops on rd_en, and keeps a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          received,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    input  logic          clear_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          prev_rcv;
    logic          push_c;
    logic          pop_c;
    logic          wr_c;
    logic          drop_c;
    logic [AW:0]   count_nxt_c;

    // A push while full only lands if a pop frees a slot in the same cycle.
    assign push_c = received & ~prev_rcv;
    assign pop_c  = rd_en & ~empty;
    assign wr_c   = push_c & (~full | pop_c);
    assign drop_c = push_c & full & ~pop_c;

    always_comb begin
        count_nxt_c = count;
        if (wr_c && !pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (!wr_c && pop_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rcv <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            prev_rcv <= received;
            count    <= count_nxt_c;
            empty    <= (count_nxt_c == CW'(0));
            full     <= (count_nxt_c == CW'(DEPTH));
            rd_valid <= pop_c;
            if (wr_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            // Set takes priority over clear.
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is intentionally not reset; reads are gated by empty.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= rx_data;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of byte entries; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter AW, default 3, meaning pointer width; it SHALL equal log2(DEPTH).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port received, input, 1 bit: byte-done level from the UART receiver; it is high when idle, low while a frame is in progress, and its rise marks rx_data valid.
REQ-006 Port rx_data, input, 8 bits: received byte, stable from the rise of received until the next frame starts.
REQ-007 Port rd_en, input, 1 bit: consumer pop request.
REQ-008 Port clear_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-009 Port rd_data, output, 8 bits: popped byte, registered.
REQ-010 Port rd_valid, output, 1 bit: one-cycle pulse qualifying rd_data.
REQ-011 Port empty, output, 1 bit: high when count is 0.
REQ-012 Port full, output, 1 bit: high when count equals DEPTH.
REQ-013 Port count, output, AW+1 bits: current occupancy, from 0 to DEPTH.
REQ-014 Port overflow, output, 1 bit: sticky flag indicating a byte was dropped.

Function
REQ-015 The block SHALL register received into prev_rcv each cycle.
REQ-016 A push SHALL occur in the cycle where received is 1 and prev_rcv is 0 (rising edge), exactly once per edge.
REQ-017 A push SHALL write rx_data to mem[wr_ptr] and advance wr_ptr by 1 modulo DEPTH.
REQ-018 A pop SHALL occur when rd_en is 1 and empty is 0.
REQ-019 On a pop, the block SHALL latch mem[rd_ptr] into rd_data, advance rd_ptr modulo DEPTH, and assert rd_valid in the next cycle; pop latency is 1 clock.
REQ-020 When no pop occurs, rd_valid SHALL be 0 and rd_data SHALL hold its previous value.
REQ-021 rd_en while empty SHALL be ignored: no pointer change and rd_valid remains 0.
REQ-022 Push and pop in the same cycle while not empty SHALL both take effect, leaving count unchanged.
REQ-023 Push and pop in the same cycle while full SHALL both take effect, with no overflow and count remaining DEPTH.
REQ-024 Push and rd_en in the same cycle while empty SHALL perform only the push; count becomes 1 and rd_valid is 0.
REQ-025 A push while full with no simultaneous pop SHALL drop the byte, leave memory, pointers and count unchanged, and set overflow.
REQ-026 overflow SHALL stay set until a cycle with clear_ovf at 1; if set and clear occur in the same cycle, set SHALL win.
REQ-027 count SHALL increment on a push-only cycle, decrement on a pop-only cycle, and hold otherwise.
REQ-028 empty and full SHALL be derived from the registered count, with no combinational path from rd_en or received.
REQ-029 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated byte.

Reset
REQ-030 While rst_n is 0: count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=8'h00, wr_ptr=0, rd_ptr=0, prev_rcv=1.
REQ-031 Since prev_rcv resets to 1, a received level already high at reset release SHALL NOT cause a push.
REQ-032 Memory contents SHALL NOT be reset, and reading from memory is only permitted behind empty=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored bytes immediately, without waiting for a clock edge.

Verification
REQ-034 Reset release with received held at 1 -> count stays 0, empty=1, no rd_valid.
REQ-035 Push 8'hA5, then one cycle of rd_en -> rd_valid pulses once with rd_data=8'hA5 one clock later, then empty=1.
REQ-036 Push 9 bytes 8'h01..8'h09 with no pops -> full=1, count=8, overflow=1; draining yields 8'h01..8'h08 in order.
REQ-037 Fill, then hold rd_en=1 continuously while pushing one byte per frame for 2*DEPTH frames -> all bytes emerge in order across pointer wrap, and overflow stays 0.
REQ-038 rd_en on the same cycle as a push into an empty FIFO -> no rd_valid, count=1; the next rd_en returns that byte.
REQ-039 With overflow=1, assert clear_ovf together with another full-drop push -> overflow stays 1; clear_ovf alone on the next cycle -> overflow becomes 0.
